// File: rtl/pll_reset_seq.sv
// PLL lock qualifier and downstream reset sequencer: synchronizes pll_lock, qualifies it, stretches reset, flags loss.
// Optional LOCK_LOSS_COUNT_EN adds an 8-bit saturating lock-loss counter output (loss_count).
module pll_reset_seq #(
    parameter int unsigned SYNC_STAGES      = 2,
    parameter int unsigned LOCK_HOLD_CYCLES = 1024,
    parameter int unsigned RST_HOLD_CYCLES  = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pll_lock,
    input  logic       clear_lost,
    output logic       sys_rst_n,
    output logic       ready,
    output logic       lock_lost,
    output logic [1:0] state
`ifdef LOCK_LOSS_COUNT_EN
    ,
    output logic [7:0] loss_count
`endif
);

    localparam int unsigned CNT_MAX = (LOCK_HOLD_CYCLES > RST_HOLD_CYCLES) ?
                                      LOCK_HOLD_CYCLES : RST_HOLD_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX) + 1;

    // HOLD_LOCK lasts LOCK_HOLD_CYCLES cycles; DRAIN lasts RST_HOLD_CYCLES+1 so release
    // lands SYNC_STAGES+LOCK_HOLD_CYCLES+RST_HOLD_CYCLES+1 edges after lock is first sampled.
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(LOCK_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(RST_HOLD_CYCLES);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        HOLD_LOCK = 2'd1,
        DRAIN     = 2'd2,
        RUN       = 2'd3
    } state_t;

    state_t                 state_q, state_nxt;
    logic [CNT_W-1:0]       cnt_q, cnt_nxt;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   lock_s;
    logic                   lost_set;
    logic                   sys_rst_n_nxt;
    logic                   lock_lost_nxt;

    assign lock_s = sync_q[SYNC_STAGES-1];
    assign state  = state_q;

    // Lock synchronizer, shifting from bit 0 toward lock_s
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pll_lock};
        end
    end

    // Next-state, counter and registered-output decode
    always_comb begin
        state_nxt = state_q;
        cnt_nxt   = cnt_q;
        lost_set  = 1'b0;
        case (state_q)
            WAIT_LOCK: begin
                cnt_nxt = '0;
                if (lock_s) state_nxt = HOLD_LOCK;
            end
            HOLD_LOCK: begin
                if (!lock_s) begin
                    state_nxt = WAIT_LOCK;
                    cnt_nxt   = '0;
                end else if (cnt_q == HOLD_LAST) begin
                    state_nxt = DRAIN;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt_q + CNT_W'(1);
                end
            end
            DRAIN: begin
                if (!lock_s) begin
                    state_nxt = WAIT_LOCK;
                    cnt_nxt   = '0;
                end else if (cnt_q == DRAIN_LAST) begin
                    state_nxt = RUN;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt_q + CNT_W'(1);
                end
            end
            RUN: begin
                cnt_nxt = '0;
                if (!lock_s) begin
                    state_nxt = WAIT_LOCK;
                    lost_set  = 1'b1;
                end
            end
            default: begin
                state_nxt = WAIT_LOCK;
                cnt_nxt   = '0;
            end
        endcase
        sys_rst_n_nxt = (state_nxt == RUN);
        lock_lost_nxt = lost_set | (lock_lost & ~clear_lost);
    end

    // State, counter and output registers; async reset drops sys_rst_n immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= WAIT_LOCK;
            cnt_q     <= '0;
            sys_rst_n <= 1'b0;
            ready     <= 1'b0;
            lock_lost <= 1'b0;
        end else begin
            state_q   <= state_nxt;
            cnt_q     <= cnt_nxt;
            sys_rst_n <= sys_rst_n_nxt;
            ready     <= sys_rst_n_nxt;
            lock_lost <= lock_lost_nxt;
        end
    end

`ifdef LOCK_LOSS_COUNT_EN
    // Saturating loss counter; a loss coinciding with a clear leaves a count of one
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            loss_count <= '0;
        end else if (lost_set && clear_lost) begin
            loss_count <= 8'd1;
        end else if (clear_lost) begin
            loss_count <= '0;
        end else if (lost_set && (loss_count != 8'hFF)) begin
            loss_count <= loss_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pll_reset_seq.sv
// Directed bench for pll_reset_seq with SYNC_STAGES=2, LOCK_HOLD_CYCLES=8, RST_HOLD_CYCLES=4.
module tb_pll_reset_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       pll_lock;
    logic       clear_lost;
    logic       sys_rst_n;
    logic       ready;
    logic       lock_lost;
    logic [1:0] state;
`ifdef LOCK_LOSS_COUNT_EN
    logic [7:0] loss_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic       lock;
        logic       clr;
        logic [1:0] st;
        logic       rst;
        logic       rdy;
        logic       lost;
    } vec_t;

    vec_t vecs[$];

    pll_reset_seq #(
        .SYNC_STAGES     (2),
        .LOCK_HOLD_CYCLES(8),
        .RST_HOLD_CYCLES (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pll_lock  (pll_lock),
        .clear_lost(clear_lost),
        .sys_rst_n (sys_rst_n),
        .ready     (ready),
        .lock_lost (lock_lost),
        .state     (state)
`ifdef LOCK_LOSS_COUNT_EN
        ,
        .loss_count(loss_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic lk, input logic cl, input logic [1:0] st,
                       input logic rs, input logic rd, input logic lo);
        vec_t v;
        v.lock = lk; v.clr = cl; v.st = st; v.rst = rs; v.rdy = rd; v.lost = lo;
        vecs.push_back(v);
    endtask

    // Lock held from edge 0: WAIT for edges 0-1, HOLD 2-9, DRAIN 10-14, RUN at 15
    task automatic add_bringup(input logic lost);
        logic [1:0] st;
        for (int i = 0; i < 16; i++) begin
            st = (i < 2) ? 2'd0 : (i < 10) ? 2'd1 : (i < 15) ? 2'd2 : 2'd3;
            add(1'b1, 1'b0, st, (i == 15), (i == 15), lost);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; pll_lock = 1'b0; clear_lost = 1'b0;
        step(); step();
        chk("reset sys_rst_n", 32'(sys_rst_n), 0);
        chk("reset ready", 32'(ready), 0);
        chk("reset lock_lost", 32'(lock_lost), 0);
        chk("reset state", 32'(state), 0);
        rst_n = 1'b1;
        step(); step();
        chk("idle state", 32'(state), 0);

        // Bring-up, lock drop in RUN, relock with sticky flag, clear, then drop+clear together
        add_bringup(1'b0);
        add(1'b0, 1'b0, 2'd3, 1'b1, 1'b1, 1'b0);
        add(1'b0, 1'b0, 2'd3, 1'b1, 1'b1, 1'b0);
        add_bringup(1'b1);
        add(1'b1, 1'b1, 2'd3, 1'b1, 1'b1, 1'b0);
        add(1'b1, 1'b0, 2'd3, 1'b1, 1'b1, 1'b0);
        add(1'b0, 1'b0, 2'd3, 1'b1, 1'b1, 1'b0);
        add(1'b0, 1'b0, 2'd3, 1'b1, 1'b1, 1'b0);
        add(1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b1);
        add(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1);

        foreach (vecs[i]) begin
            pll_lock   = vecs[i].lock;
            clear_lost = vecs[i].clr;
            step();
            chk($sformatf("vec%0d state", i), 32'(state), 32'(vecs[i].st));
            chk($sformatf("vec%0d sys_rst_n", i), 32'(sys_rst_n), 32'(vecs[i].rst));
            chk($sformatf("vec%0d ready", i), 32'(ready), 32'(vecs[i].rdy));
            chk($sformatf("vec%0d lock_lost", i), 32'(lock_lost), 32'(vecs[i].lost));
        end
        clear_lost = 1'b0;

        // One-cycle lock glitch at HOLD count 5 restarts qualification
        rst_n = 1'b0; step(); rst_n = 1'b1;
        pll_lock = 1'b1;
        for (int e = 0; e <= 7; e++) step();
        chk("glitch pre state", 32'(state), 1);
        pll_lock = 1'b0; step();
        pll_lock = 1'b1; step();
        step();
        chk("glitch restart state", 32'(state), 0);
        for (int e = 11; e <= 24; e++) begin
            step();
            if (e == 23) chk("glitch rst edge23", 32'(sys_rst_n), 0);
            if (e == 24) chk("glitch rst edge24", 32'(sys_rst_n), 1);
        end

        // Async reset pulse between edges while in RUN
        #2; rst_n = 1'b0; #1;
        chk("async sys_rst_n", 32'(sys_rst_n), 0);
        chk("async state", 32'(state), 0);
        chk("async ready", 32'(ready), 0);
        #2; rst_n = 1'b1;
        for (int e = 0; e <= 15; e++) begin
            step();
            if (e == 14) chk("requal rst edge14", 32'(sys_rst_n), 0);
            if (e == 15) begin
                chk("requal rst edge15", 32'(sys_rst_n), 1);
                chk("requal state edge15", 32'(state), 3);
            end
        end

`ifdef LOCK_LOSS_COUNT_EN
        for (int n = 0; n < 260; n++) begin
            pll_lock = 1'b0; repeat (3) step();
            pll_lock = 1'b1; repeat (16) step();
        end
        chk("loss_count sat", 32'(loss_count), 255);
        clear_lost = 1'b1; step(); clear_lost = 1'b0;
        chk("loss_count clear", 32'(loss_count), 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
